fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 13 +
 rtl/fetch_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller:
// FSM state encoding and the default post-reset fetch address.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory access at a time,
// a single-entry output register to decode, and branch redirect with drain.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          imReq,
    output logic [AW-1:0] imAddr,
    input  logic          imAck,
    input  logic [15:0]   imData,
    input  logic          brValid,
    input  logic [AW-1:0] brTarget,
    input  logic          stall,
    output logic          fValid,
    output logic [15:0]   fInst,
    output logic [AW-1:0] fPc
);

    fetch_state_e  state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [AW-1:0] req_addr, req_addr_nxt;
    logic          valid_nxt;
    logic [15:0]   inst_nxt;
    logic [AW-1:0] fpc_nxt;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        // A held instruction leaves when decode is not stalling.
        valid_nxt    = fValid && stall;
        inst_nxt     = fInst;
        fpc_nxt      = fPc;

        case (state)
            ST_IDLE: begin
                // Only start a fetch when the output slot is free or draining now.
                if (!brValid && (!fValid || !stall)) begin
                    state_nxt    = ST_REQ;
                    req_addr_nxt = pc;
                end
            end
            ST_REQ: begin
                if (imAck) begin
                    state_nxt = ST_IDLE;
                    if (!brValid) begin
                        inst_nxt  = imData;
                        fpc_nxt   = req_addr;
                        valid_nxt = 1'b1;
                        pc_nxt    = req_addr + AW'(1);
                    end
                end else if (brValid) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Access cannot be aborted; wait for the ack and drop the data.
                if (imAck) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Redirect overrides everything, including a same-cycle load.
        if (brValid) begin
            pc_nxt    = brTarget;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            fValid   <= 1'b0;
            fInst    <= 16'h0000;
            fPc      <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            fValid   <= valid_nxt;
            fInst    <= inst_nxt;
            fPc      <= fpc_nxt;
        end
    end

    assign imReq  = (state != ST_IDLE);
    assign imAddr = req_addr;

endmodule
